// File: rtl/cpu_pkg.sv
// cpu_pkg: shared scoreboard entry type and register constants for decode hazard logic
package cpu_pkg;
   localparam int DEST_MAX = 8;
   localparam logic [4:0] XZR = 5'd31;
   localparam logic [4:0] X30 = 5'd30;
   localparam int FWD_RF = 0;
   typedef struct packed {
      logic                valid;
      logic [DEST_MAX-1:0] dest;
      logic                regwrite;
      logic                memread;
      logic                setflags;
   } sb_entry_t;
endpackage

// File: rtl/id_hazard_scoreboard_if.sv
// id_hazard_scoreboard_if: decode-stage instruction fields in, forwarding/stall controls out
interface id_hazard_scoreboard_if #(parameter int NSRC = 2, REGW = 5, SELW = 2, CNTW = 16);
   logic                 id_valid;
   logic [NSRC*REGW-1:0] id_src;
   logic [NSRC-1:0]      id_src_used;
   logic [REGW-1:0]      id_dest;
   logic                 id_regwrite;
   logic                 id_memread;
   logic                 id_setflags;
   logic                 id_uses_flags;
   logic                 flush;
   logic [NSRC*SELW-1:0] fwd_sel;
   logic                 fwd_flags;
   logic                 stall;
   logic [CNTW-1:0]      stall_count;
   modport master (output id_valid, id_src, id_src_used, id_dest, id_regwrite, id_memread,
                   id_setflags, id_uses_flags, flush,
                   input fwd_sel, fwd_flags, stall, stall_count);
   modport slave (input id_valid, id_src, id_src_used, id_dest, id_regwrite, id_memread,
                  id_setflags, id_uses_flags, flush,
                  output fwd_sel, fwd_flags, stall, stall_count);
endinterface

// File: rtl/id_hazard_scoreboard_operand_match.sv
// operand_match: priority-encodes the youngest in-flight producer of one source operand
module operand_match import cpu_pkg::*; #(parameter int DEPTH = 3, REGW = 5, SELW = 2) (
   input  sb_entry_t       sb [1:DEPTH],
   input  logic [REGW-1:0] src,
   input  logic            used,
   output logic [SELW-1:0] sel
);
   logic [DEST_MAX-1:0] key;
   assign key = DEST_MAX'(src);
   // scan oldest to youngest so the smallest matching stage is the one left in sel
   always_comb begin
      sel = SELW'(FWD_RF);
      for (int s = DEPTH; s >= 1; s--)
         if (used && src != REGW'(XZR) && sb[s].valid && sb[s].regwrite && sb[s].dest == key)
            sel = SELW'(s);
   end
endmodule

// File: rtl/id_hazard_scoreboard.sv
// id_hazard_scoreboard: tracks DEPTH downstream stages to drive operand/flag forwarding,
// load-use stalls and a saturating stall counter for the decode stage
module id_hazard_scoreboard import cpu_pkg::*; #(
   parameter int DEPTH = 3, NSRC = 2, REGW = 5, SELW = 2, CNTW = 16
) (
   input logic                   clk,
   input logic                   reset,
   id_hazard_scoreboard_if.slave bus
);
   sb_entry_t       sb [1:DEPTH];
   logic [NSRC-1:0] hit1;
   logic [CNTW-1:0] cnt;
   genvar k;
   for (k = 0; k < NSRC; k++) begin : g_src
      logic [SELW-1:0] sel;
      operand_match #(.DEPTH(DEPTH), .REGW(REGW), .SELW(SELW)) u_match (
         .sb(sb), .src(bus.id_src[k*REGW +: REGW]), .used(bus.id_src_used[k]), .sel(sel));
      assign bus.fwd_sel[k*SELW +: SELW] = sel;
      assign hit1[k] = sel == SELW'(1);
   end
   assign bus.stall       = bus.id_valid & ~bus.flush & sb[1].memread & |hit1;
   assign bus.fwd_flags   = bus.id_uses_flags & sb[1].valid & sb[1].setflags;
   assign bus.stall_count = cnt;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         for (int s = 1; s <= DEPTH; s++) sb[s] <= '0;
         cnt <= '0;
      end else begin
         sb[1] <= (bus.id_valid & ~bus.stall & ~bus.flush) ?
                  sb_entry_t'{valid: 1'b1, dest: DEST_MAX'(bus.id_dest), regwrite: bus.id_regwrite,
                              memread: bus.id_memread, setflags: bus.id_setflags} : '0;
         for (int s = 2; s <= DEPTH; s++) sb[s] <= sb[s-1];
         if (bus.stall && cnt != '1) cnt <= cnt + CNTW'(1);
      end
endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// tb_id_hazard_scoreboard: scenario-driven bench with an expected-result queue
module tb_id_hazard_scoreboard;
   logic clk = 0, reset = 1;
   int n_chk = 0, n_fail = 0;
   logic [5:0] q[$];
   logic [5:0] e, obs;
   id_hazard_scoreboard_if #(.NSRC(2), .REGW(5), .SELW(2), .CNTW(4)) bus();
   id_hazard_scoreboard #(.DEPTH(3), .NSRC(2), .REGW(5), .SELW(2), .CNTW(4)) dut (
      .clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   assign obs = {bus.fwd_sel, bus.fwd_flags, bus.stall};

   function automatic logic [5:0] ex(input logic [1:0] s1, input logic [1:0] s0, input logic ff, input logic st);
      return {s1, s0, ff, st};
   endfunction

   task automatic drive(input logic v, input logic [4:0] a, input logic [4:0] b, input logic [1:0] u,
                        input logic [4:0] d, input logic rw, input logic mr, input logic sf,
                        input logic uf, input logic fl);
      bus.id_valid = v; bus.id_src = {b, a}; bus.id_src_used = u; bus.id_dest = d;
      bus.id_regwrite = rw; bus.id_memread = mr; bus.id_setflags = sf;
      bus.id_uses_flags = uf; bus.flush = fl;
   endtask

   task automatic issue(input logic v, input logic [4:0] a, input logic [4:0] b, input logic [1:0] u,
                        input logic [4:0] d, input logic rw, input logic mr, input logic sf,
                        input logic uf, input logic fl, input logic [5:0] exp_o);
      @(posedge clk); #1;
      drive(v, a, b, u, d, rw, mr, sf, uf, fl);
      q.push_back(exp_o);
      @(negedge clk);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
      end
   endtask

   task automatic test_reset;
      drive(1, 5'd1, 5'd2, 2'b11, 5'd1, 1, 1, 1, 1, 0);
      #3;
      n_chk++; if (obs !== 6'b0) begin n_fail++; $display("FAIL reset_outputs got=%b want=%b", obs, 6'b0); end
      n_chk++; if (bus.stall_count !== 4'd0) begin n_fail++; $display("FAIL reset_count got=%0d want=0", bus.stall_count); end
      drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0);
      @(negedge clk); reset = 0;
   endtask

   task automatic test_ex_forward;
      issue(1, 5'd2, 5'd3, 2'b11, 5'd1, 1, 0, 1, 0, 0, ex(0, 0, 0, 0));
      e = q.pop_front(); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL adds_first got=%b want=%b", obs, e); end
      issue(1, 5'd1, 5'd5, 2'b11, 5'd4, 1, 0, 0, 0, 0, ex(0, 1, 0, 0));
      e = q.pop_front(); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL ex_forward got=%b want=%b", obs, e); end
   endtask

   task automatic test_mem_forward;
      issue(1, 5'd2, 5'd3, 2'b11, 5'd1, 1, 0, 0, 0, 0, ex(0, 0, 0, 0));
      e = q.pop_front(); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL add_x1 got=%b want=%b", obs, e); end
      issue(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0));
      e = q.pop_front(); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL nop got=%b want=%b", obs, e); end
      issue(1, 5'd1, 5'd1, 2'b11, 5'd6, 1, 0, 0, 0, 0, ex(2, 2, 0, 0));
      e = q.pop_front(); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL mem_forward got=%b want=%b", obs, e); end
      issue(1, 5'd2, 5'd3, 2'b11, 5'd1, 1, 0, 0, 0, 0, ex(0, 0, 0, 0));
      e = q.pop_front(); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL add_x1_a got=%b want=%b", obs, e); end
      issue(1, 5'd2, 5'd3, 2'b11, 5'd1, 1, 0, 0, 0, 0, ex(0, 0, 0, 0));
      e = q.pop_front(); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL add_x1_b got=%b want=%b", obs, e); end
      issue(1, 5'd1, 5'd1, 2'b11, 5'd9, 1, 0, 0, 0, 0, ex(1, 1, 0, 0));
      e = q.pop_front(); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL youngest_wins got=%b want=%b", obs, e); end
   endtask

   task automatic test_load_use;
      idle(3);
      issue(1, 5'd0, 5'd0, 2'b01, 5'd7, 1, 1, 0, 0, 0, ex(0, 0, 0, 0));
      e = q.pop_front(); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL ldur got=%b want=%b", obs, e); end
      issue(1, 5'd7, 5'd9, 2'b11, 5'd8, 1, 0, 0, 0, 0, ex(0, 1, 0, 1));
      e = q.pop_front(); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL load_use_stall got=%b want=%b", obs, e); end
      issue(1, 5'd7, 5'd9, 2'b11, 5'd8, 1, 0, 0, 0, 0, ex(0, 2, 0, 0));
      e = q.pop_front(); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL load_use_release got=%b want=%b", obs, e); end
      n_chk++; if (bus.stall_count !== 4'd1) begin n_fail++; $display("FAIL load_use_count got=%0d want=1", bus.stall_count); end
   endtask

   task automatic test_flags;
      issue(1, 5'd2, 5'd3, 2'b11, 5'd1, 1, 0, 1, 0, 0, ex(0, 0, 0, 0));
      e = q.pop_front(); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL subs got=%b want=%b", obs, e); end
      issue(1, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, ex(0, 0, 1, 0));
      e = q.pop_front(); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL flag_forward got=%b want=%b", obs, e); end
      issue(1, 5'd2, 5'd3, 2'b11, 5'd1, 1, 0, 1, 0, 0, ex(0, 0, 0, 0));
      e = q.pop_front(); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL subs_2 got=%b want=%b", obs, e); end
      issue(0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, ex(0, 0, 0, 0));
      e = q.pop_front(); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL flag_nop got=%b want=%b", obs, e); end
      issue(1, 0, 0, 2'b00, 0, 0, 0, 0, 1, 0, ex(0, 0, 0, 0));
      e = q.pop_front(); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL flag_stage2 got=%b want=%b", obs, e); end
   endtask

   task automatic test_flush_xzr;
      idle(3);
      issue(1, 5'd0, 5'd0, 2'b01, 5'd7, 1, 1, 0, 0, 0, ex(0, 0, 0, 0));
      e = q.pop_front(); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL ldur_f got=%b want=%b", obs, e); end
      issue(1, 5'd7, 5'd9, 2'b11, 5'd7, 1, 0, 0, 0, 1, ex(0, 1, 0, 0));
      e = q.pop_front(); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL flush_no_stall got=%b want=%b", obs, e); end
      issue(1, 5'd7, 5'd9, 2'b11, 5'd7, 1, 0, 0, 0, 0, ex(0, 2, 0, 0));
      e = q.pop_front(); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL flush_bubble got=%b want=%b", obs, e); end
      n_chk++; if (bus.stall_count !== 4'd1) begin n_fail++; $display("FAIL flush_count got=%0d want=1", bus.stall_count); end
      issue(1, 5'd2, 5'd3, 2'b11, 5'd31, 1, 0, 0, 0, 0, ex(0, 0, 0, 0));
      e = q.pop_front(); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL write_xzr got=%b want=%b", obs, e); end
      issue(1, 5'd31, 5'd31, 2'b11, 5'd5, 1, 0, 0, 0, 0, ex(0, 0, 0, 0));
      e = q.pop_front(); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL xzr_no_fwd got=%b want=%b", obs, e); end
   endtask

   task automatic test_saturate_reset;
      idle(3);
      for (int i = 0; i < 42; i++) begin
         issue(1, 5'd7, 5'd0, 2'b01, 5'd7, 1, 1, 0, 0, 0,
               i == 0 ? ex(0, 0, 0, 0) : (i % 2 == 1) ? ex(0, 1, 0, 1) : ex(0, 2, 0, 0));
         e = q.pop_front(); n_chk++;
         if (obs !== e) begin n_fail++; $display("FAIL sat_step%0d got=%b want=%b", i, obs, e); end
      end
      n_chk++; if (bus.stall_count !== 4'd15) begin n_fail++; $display("FAIL saturate got=%0d want=15", bus.stall_count); end
      #2 reset = 1; bus.id_valid = 0;
      #1;
      n_chk++; if (bus.stall_count !== 4'd0) begin n_fail++; $display("FAIL async_count got=%0d want=0", bus.stall_count); end
      n_chk++; if (bus.stall !== 1'b0) begin n_fail++; $display("FAIL async_stall got=%b want=0", bus.stall); end
      n_chk++; if (obs !== 6'b0) begin n_fail++; $display("FAIL async_outputs got=%b want=%b", obs, 6'b0); end
      #1 reset = 0;
      issue(1, 5'd7, 5'd9, 2'b11, 5'd8, 1, 0, 0, 0, 0, ex(0, 0, 0, 0));
      e = q.pop_front(); n_chk++; if (obs !== e) begin n_fail++; $display("FAIL post_reset got=%b want=%b", obs, e); end
      n_chk++; if (bus.stall_count !== 4'd0) begin n_fail++; $display("FAIL post_reset_count got=%0d want=0", bus.stall_count); end
   endtask

   initial begin
      test_reset;
      test_ex_forward;
      test_mem_forward;
      test_load_use;
      test_flags;
      test_flush_xzr;
      test_saturate_reset;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
